// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/HOLD sequencer.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch #(
    parameter int unsigned RESET_PC  = 100,
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        misalign_err
);

    // state | meaning
    // BOOT  | first cycle after reset, IF/ID holds no valid fetch yet
    // RUN   | fetching one word per cycle
    // HOLD  | stalled, PC and IF/ID frozen
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

    // Word-aligned address inside the memory window; wraps both increments and redirects.
    localparam logic [31:0] ADDR_MASK = (32'(MEM_BYTES) - 32'd1) & ~32'd3;
    localparam logic [31:0] PC_RST    = 32'(RESET_PC) & ADDR_MASK;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        do_fetch;
    logic [31:0] pc_plus4;

    assign pc_plus4 = (pc_q + 32'd4) & ADDR_MASK;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        mis_d    = 1'b0;
        do_fetch = 1'b0;
        if (redirect) begin
            state_d = RUN;
            pc_d    = redirect_pc & ADDR_MASK;
            instr_d = 32'd0;
            valid_d = 1'b0;
            mis_d   = |redirect_pc[1:0];
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_d  = RUN;
                    do_fetch = !stall;
                end
                RUN: begin
                    if (stall) state_d = HOLD;
                    else       do_fetch = 1'b1;
                end
                HOLD: begin
                    if (!stall) begin
                        state_d  = RUN;
                        do_fetch = 1'b1;
                    end
                end
                default: state_d = BOOT;
            endcase
            if (do_fetch) begin
                instr_d = instruction;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= PC_RST;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, scnt_q;
    logic        stall_inc;

    // Stall edges are those that enter or remain in HOLD; a redirect cancels the stall.
    assign stall_inc = !redirect && stall && (state_q != BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 32'd0;
            scnt_q <= 32'd0;
        end else begin
            if (do_fetch)  fcnt_q <= fcnt_q + 32'd1;
            if (stall_inc) scnt_q <= scnt_q + 32'd1;
        end
    end

    assign fetch_count = fcnt_q;
    assign stall_count = scnt_q;
`endif

    assign pc           = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural fetch model.
module tb_instruction_fetch;

    localparam int unsigned MEM = 16384;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:MEM/4-1];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch #(.RESET_PC(100), .MEM_BYTES(MEM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .instruction  (instruction),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count  (fetch_count),
        .stall_count  (stall_count),
`endif
        .misalign_err (misalign_err)
    );

    // Big-endian word memory, one word per 4 bytes, read combinationally.
    assign instruction = mem[pc[13:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        int          exp_iaddr;   // byte address of the expected IF/ID word, -1 for a bubble
        logic [31:0] exp_pc4;
        logic        exp_valid;
        logic        exp_mis;
    } vec_t;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;
    logic        m_valid, m_mis, m_boot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return mem[(addr % MEM) / 4];
    endfunction

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'd100; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
        m_boot = 1'b1; m_fcnt = 0; m_scnt = 0;
    endtask

    task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
        m_mis = 1'b0;
        if (rd) begin
            m_pc    = (rpc % MEM) / 4 * 4;
            m_instr = 0;
            m_valid = 0;
            m_mis   = (rpc % 4) != 0;
        end else if (st) begin
            if (!m_boot) m_scnt++;
        end else begin
            m_instr = word_at(m_pc);
            m_pc4   = (m_pc + 4) % MEM;
            m_pc    = m_pc4;
            m_valid = 1;
            m_fcnt++;
        end
        m_boot = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},    pc, 32'd100);
        check({tag, "_instr"}, if_id_instr, 32'd0);
        check({tag, "_pc4"},   if_id_pc4, 32'd0);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, "_mis"},   {31'd0, misalign_err}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        for (int i = 0; i < MEM/4; i++) mem[i] = $urandom;
        mem[25] = 32'h4808_0000;
        mem[26] = 32'h4809_0004;

        vecs.push_back('{0, 0, 0,     104,   100,   104,   1, 0});
        vecs.push_back('{0, 0, 0,     108,   104,   108,   1, 0});
        vecs.push_back('{0, 1, 208,   208,   -1,    108,   0, 0});
        vecs.push_back('{1, 0, 0,     208,   -1,    108,   0, 0});
        vecs.push_back('{1, 0, 0,     208,   -1,    108,   0, 0});
        vecs.push_back('{1, 0, 0,     208,   -1,    108,   0, 0});
        vecs.push_back('{0, 0, 0,     212,   208,   212,   1, 0});
        vecs.push_back('{1, 0, 0,     212,   208,   212,   1, 0});
        vecs.push_back('{0, 0, 0,     216,   212,   216,   1, 0});
        vecs.push_back('{1, 1, 728,   728,   -1,    216,   0, 0});
        vecs.push_back('{0, 0, 0,     732,   728,   732,   1, 0});
        vecs.push_back('{0, 1, 102,   100,   -1,    732,   0, 1});
        vecs.push_back('{0, 0, 0,     104,   100,   104,   1, 0});
        vecs.push_back('{0, 1, 16380, 16380, -1,    104,   0, 0});
        vecs.push_back('{0, 0, 0,     0,     16380, 0,     1, 0});
        vecs.push_back('{0, 0, 0,     4,     0,     4,     1, 0});
        vecs.push_back('{0, 1, 16392, 8,     -1,    4,     0, 0});
        vecs.push_back('{0, 1, 7,     4,     -1,    4,     0, 1});
        vecs.push_back('{1, 0, 0,     4,     -1,    4,     0, 0});
        vecs.push_back('{0, 0, 0,     8,     4,     8,     1, 0});

        // Reset held: outputs at reset values regardless of clock
        #12;
        check_reset_values("rst_hold");

        do_reset();
        check("boot_pc", pc, 32'd100);
        check("boot_valid", {31'd0, if_id_valid}, 32'd0);

        foreach (vecs[i]) begin
            logic [31:0] exp_instr;
            exp_instr = (vecs[i].exp_iaddr < 0) ? 32'd0 : word_at(32'(vecs[i].exp_iaddr));
            step(vecs[i].st, vecs[i].rd, vecs[i].rpc);
            check($sformatf("vec%0d_pc", i),    pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), if_id_instr, exp_instr);
            check($sformatf("vec%0d_pc4", i),   if_id_pc4, vecs[i].exp_pc4);
            check($sformatf("vec%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_mis", i),   {31'd0, misalign_err}, {31'd0, vecs[i].exp_mis});
        end
        check("first_word_const", word_at(32'd100), 32'h4808_0000);

        // Asynchronous reset mid-stall and while a redirect is held
        step(0, 0, 0);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'd900;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk); #1;
        check_reset_values("rst_redir");

        // Redirect on the BOOT edge
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 400);
        check("boot_redir_pc", pc, 32'd400);
        check("boot_redir_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0);
        check("boot_redir_instr", if_id_instr, word_at(32'd400));
        check("boot_redir_pc4", if_id_pc4, 32'd404);
        check("boot_redir_valid2", {31'd0, if_id_valid}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("perf_fetch", fetch_count, 32'd5);
        check("perf_stall", stall_count, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("perf_fetch_rst", fetch_count, 32'd0);
        check("perf_stall_rst", stall_count, 32'd0);
`endif

        // Randomized run against the behavioural model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        st, rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MEM - 1));
            step(st, rd, rpc);
            model_step(st, rd, rpc);
            check("rnd_pc", pc, m_pc);
            check("rnd_instr", if_id_instr, m_instr);
            check("rnd_pc4", if_id_pc4, m_pc4);
            check("rnd_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            check("rnd_mis", {31'd0, misalign_err}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
            check("rnd_fcnt", fetch_count, m_fcnt);
            check("rnd_scnt", stall_count, m_scnt);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
